// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the fetch program counter. Every cycle the PC advances
// by 4, holds on a stall, or is redirected by a trap, jump or taken branch.
// Each accepted redirect is followed by FLUSH_CYCLES bubble cycles.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_BOOT  | one cycle after reset; requests ignored, PC = RESET_VECTOR
// ST_RUN   | normal fetch; redirects accepted, stall holds the PC
// ST_FLUSH | bubbles after a redirect; only Trap is honoured
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0080,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Branch_Taken,
    input  logic [31:0] Branch_Base,
    input  logic [31:0] Branch_Offset,
    input  logic        Jump,
    input  logic [31:0] Jump_Target,
    input  logic        Trap,
    output logic [31:0] PC,
    output logic [31:0] PC_Plus4,
    output logic        Fetch_Valid,
    output logic        Flush,
    output logic        Err_Align
);

    // Down-counter reload value; the counter reaching zero ends the flush.
    localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        err_align_q, err_align_d;

    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic        jump_misaligned;

    assign pc_plus4        = pc_q + 32'd4;
    assign branch_target   = Branch_Base + 32'd4 + (Branch_Offset << 2);
    assign jump_misaligned = (Jump_Target[1:0] != 2'b00);

    // Next-state, next-PC and flush counter selection with redirect priority.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        cnt_d       = cnt_q;
        err_align_d = 1'b0;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (Trap) begin
                    pc_d    = TRAP_VECTOR;
                    cnt_d   = FLUSH_LOAD;
                    state_d = ST_FLUSH;
                end else if (Jump && jump_misaligned) begin
                    pc_d        = TRAP_VECTOR;
                    cnt_d       = FLUSH_LOAD;
                    state_d     = ST_FLUSH;
                    err_align_d = 1'b1;
                end else if (Jump) begin
                    pc_d    = Jump_Target;
                    cnt_d   = FLUSH_LOAD;
                    state_d = ST_FLUSH;
                end else if (Branch_Taken) begin
                    pc_d    = branch_target;
                    cnt_d   = FLUSH_LOAD;
                    state_d = ST_FLUSH;
                end else if (!Stall) begin
                    pc_d = pc_plus4;
                end
            end
            ST_FLUSH: begin
                // Jump/branch here come from squashed instructions; only a
                // trap can redirect again, and it restarts the full flush.
                if (Trap) begin
                    pc_d  = TRAP_VECTOR;
                    cnt_d = FLUSH_LOAD;
                end else if (cnt_q == 2'd0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // State, PC, counter and alignment-error registers; reset wins over all.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= ST_BOOT;
            pc_q        <= RESET_VECTOR;
            cnt_q       <= 2'd0;
            err_align_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            cnt_q       <= cnt_d;
            err_align_q <= err_align_d;
        end
    end

    assign PC          = pc_q;
    assign PC_Plus4    = pc_plus4;
    assign Fetch_Valid = (state_q == ST_RUN) && !Stall;
    assign Flush       = (state_q == ST_FLUSH);
    assign Err_Align   = err_align_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: two instances (1 and 3 flush cycles) share one
// stimulus stream; a behavioural model of each is checked every cycle.
module tb_pc_sequencer;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0080;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Stall = 1'b0;
    logic        Branch_Taken = 1'b0;
    logic [31:0] Branch_Base = '0;
    logic [31:0] Branch_Offset = '0;
    logic        Jump = 1'b0;
    logic [31:0] Jump_Target = '0;
    logic        Trap = 1'b0;

    logic [31:0] pc_o  [2];
    logic [31:0] pcp_o [2];
    logic        fv_o  [2];
    logic        fl_o  [2];
    logic        ea_o  [2];

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    pc_sequencer u0 (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .Branch_Taken(Branch_Taken),
        .Branch_Base(Branch_Base), .Branch_Offset(Branch_Offset), .Jump(Jump),
        .Jump_Target(Jump_Target), .Trap(Trap), .PC(pc_o[0]), .PC_Plus4(pcp_o[0]),
        .Fetch_Valid(fv_o[0]), .Flush(fl_o[0]), .Err_Align(ea_o[0])
    );

    pc_sequencer #(.FLUSH_CYCLES(3)) u1 (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .Branch_Taken(Branch_Taken),
        .Branch_Base(Branch_Base), .Branch_Offset(Branch_Offset), .Jump(Jump),
        .Jump_Target(Jump_Target), .Trap(Trap), .PC(pc_o[1]), .PC_Plus4(pcp_o[1]),
        .Fetch_Valid(fv_o[1]), .Flush(fl_o[1]), .Err_Align(ea_o[1])
    );

    // Behavioural model: booting flag, bubbles left, expected PC and pulse.
    logic [31:0] m_pc   [2];
    bit          m_ok   [2] = '{0, 0};
    bit          m_boot [2];
    int          m_fl   [2];
    bit          m_err  [2];

    function automatic int fc(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(posedge Clk) begin
        for (int k = 0; k < 2; k++) begin
            m_err[k] = 1'b0;
            if (Reset) begin
                m_ok[k] = 1'b1; m_pc[k] = RV; m_boot[k] = 1'b1; m_fl[k] = 0;
            end else if (!m_ok[k]) begin
                m_ok[k] = 1'b0;
            end else if (m_boot[k]) begin
                m_boot[k] = 1'b0;
            end else if (m_fl[k] > 0) begin
                if (Trap) begin m_pc[k] = TV; m_fl[k] = fc(k); end
                else m_fl[k] = m_fl[k] - 1;
            end else if (Trap) begin
                m_pc[k] = TV; m_fl[k] = fc(k);
            end else if (Jump && (Jump_Target % 4 != 0)) begin
                m_pc[k] = TV; m_fl[k] = fc(k); m_err[k] = 1'b1;
            end else if (Jump) begin
                m_pc[k] = Jump_Target; m_fl[k] = fc(k);
            end else if (Branch_Taken) begin
                m_pc[k] = Branch_Base + 4 + Branch_Offset * 4; m_fl[k] = fc(k);
            end else if (!Stall) begin
                m_pc[k] = m_pc[k] + 4;
            end
        end
    end

    // Compare every output of both instances against the model, mid-cycle.
    always @(negedge Clk) begin
        for (int k = 0; k < 2; k++) begin
            if (m_ok[k]) begin
                chk($sformatf("pc[%0d]", k), pc_o[k], m_pc[k]);
                chk($sformatf("pc_plus4[%0d]", k), pcp_o[k], m_pc[k] + 32'd4);
                chk($sformatf("fetch_valid[%0d]", k), 32'(fv_o[k]),
                    32'(!m_boot[k] && m_fl[k] == 0 && !Stall));
                chk($sformatf("flush[%0d]", k), 32'(fl_o[k]), 32'(m_fl[k] > 0));
                chk($sformatf("err_align[%0d]", k), 32'(ea_o[k]), 32'(m_err[k]));
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clr();
        Stall = 1'b0; Branch_Taken = 1'b0; Jump = 1'b0; Trap = 1'b0;
    endtask

    initial begin
        // Reset held with noise on the request lines.
        for (int i = 0; i < 3; i++) begin
            Stall = i[0]; Jump = ~i[0]; Jump_Target = 32'h40;
            tick();
            chk("rst_pc", pc_o[0], 32'h0);
            chk("rst_fv", 32'(fv_o[0]), 32'h0);
            chk("rst_flush", 32'(fl_o[0]), 32'h0);
        end
        Reset = 1'b0; clr(); #1;
        chk("boot_fv", 32'(fv_o[0]), 32'h0);
        tick(); chk("run_pc0", pc_o[0], 32'h0); chk("run_fv", 32'(fv_o[0]), 32'h1);
        tick(); chk("run_pc4", pc_o[0], 32'h4);
        tick(); chk("run_pc8", pc_o[0], 32'h8);
        tick(); tick(); chk("run_pc10", pc_o[0], 32'h10);

        // Stall holds the PC.
        Stall = 1'b1;
        repeat (5) begin
            tick(); chk("stall_pc", pc_o[0], 32'h10); chk("stall_fv", 32'(fv_o[0]), 32'h0);
        end
        Stall = 1'b0;
        tick(); chk("unstall_pc", pc_o[0], 32'h14);

        // Branch with negative offset, then the same under stall.
        for (int r = 0; r < 2; r++) begin
            Branch_Taken = 1'b1; Branch_Base = 32'h20; Branch_Offset = 32'hFFFF_FFFD;
            Stall = r[0];
            tick(); clr();
            chk("br_pc", pc_o[0], 32'h18);
            chk("br_flush", 32'(fl_o[0]), 32'h1);
            chk("br_fv", 32'(fv_o[0]), 32'h0);
            tick(); chk("br_resume_pc", pc_o[0], 32'h18); chk("br_resume_fv", 32'(fv_o[0]), 32'h1);
            tick(); chk("br_next_pc", pc_o[0], 32'h1C);
        end

        // Jump beats branch; misaligned jump traps with one Err_Align pulse.
        Jump = 1'b1; Jump_Target = 32'h100; Branch_Taken = 1'b1; Branch_Offset = 32'h10;
        tick(); clr();
        chk("jmp_pc", pc_o[0], 32'h100); chk("jmp_err", 32'(ea_o[0]), 32'h0);
        tick(); chk("jmp_resume", pc_o[0], 32'h100);
        Jump = 1'b1; Jump_Target = 32'h102;
        tick(); clr();
        chk("mis_pc", pc_o[0], 32'h80); chk("mis_err", 32'(ea_o[0]), 32'h1);
        tick(); chk("mis_err_end", 32'(ea_o[0]), 32'h0); chk("mis_resume", pc_o[0], 32'h80);

        // Wrap-around past the top of the address space.
        Jump = 1'b1; Jump_Target = 32'hFFFF_FFF8;
        tick(); clr(); chk("wrap_jmp", pc_o[0], 32'hFFFF_FFF8);
        tick(); chk("wrap_a", pc_o[0], 32'hFFFF_FFF8);
        tick(); chk("wrap_b", pc_o[0], 32'hFFFF_FFFC); chk("wrap_p4", pcp_o[0], 32'h0);
        tick(); chk("wrap_c", pc_o[0], 32'h0);

        // Reset in the middle of a flush, together with a trap.
        Jump = 1'b1; Jump_Target = 32'h300;
        tick(); clr();
        Reset = 1'b1; Trap = 1'b1;
        tick(); clr();
        chk("rstfl_pc0", pc_o[0], RV); chk("rstfl_fl0", 32'(fl_o[0]), 32'h0);
        chk("rstfl_pc1", pc_o[1], RV); chk("rstfl_fl1", 32'(fl_o[1]), 32'h0);
        Reset = 1'b0;
        tick();

        // Three-cycle flush: trap in the 2nd flush cycle restarts it.
        Jump = 1'b1; Jump_Target = 32'h200;
        tick(); clr(); chk("f3_jmp", pc_o[1], 32'h200); chk("f3_fl", 32'(fl_o[1]), 32'h1);
        tick();
        Trap = 1'b1;
        tick(); clr(); chk("f3_trap", pc_o[1], 32'h80); chk("f3_fl_a", 32'(fl_o[1]), 32'h1);
        Jump = 1'b1; Jump_Target = 32'h300;
        tick(); clr(); chk("f3_ign", pc_o[1], 32'h80); chk("f3_fl_b", 32'(fl_o[1]), 32'h1);
        tick(); chk("f3_fl_c", 32'(fl_o[1]), 32'h1);
        tick(); chk("f3_end", 32'(fl_o[1]), 32'h0); chk("f3_fv", 32'(fv_o[1]), 32'h1);
        chk("f3_pc", pc_o[1], 32'h80);
        tick(); chk("f3_next", pc_o[1], 32'h84);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            Reset         = ($urandom_range(99) == 0);
            Stall         = ($urandom_range(3) == 0);
            Trap          = ($urandom_range(19) == 0);
            Jump          = ($urandom_range(9) == 0);
            Jump_Target   = $urandom;
            if ($urandom_range(3) != 0) Jump_Target[1:0] = 2'b00;
            Branch_Taken  = ($urandom_range(7) == 0);
            Branch_Base   = $urandom & 32'hFFFF_FFFC;
            Branch_Offset = ($urandom_range(1) == 0) ? 32'($signed($urandom_range(64)) - 32) : $urandom;
            tick();
        end
        clr(); Reset = 1'b0;
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
